// File: rtl/async_fifo_pkg.sv
// Shared types and constants for the async FIFO read-side stage.
package async_fifo_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } rd_state_t;

    localparam int RD_BUF_DEPTH = 3;
    localparam int FIFO_DWIDTH  = 8;

    // Pointers walk 0,1,2 and never take the value 3.
    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/rd_elastic_buf.sv
// Three-entry circular buffer: write at tail, read at head, clear drops everything.
module rd_elastic_buf
    import async_fifo_pkg::*;
#(
    parameter int DWIDTH = FIFO_DWIDTH
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] head_data,
    output logic [1:0]        count
);

    logic [DWIDTH-1:0] mem_q [RD_BUF_DEPTH];
    logic [DWIDTH-1:0] mem_d [RD_BUF_DEPTH];
    logic [1:0]        head_q, head_d;
    logic [1:0]        tail_q, tail_d;
    logic [1:0]        count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = 2'd0;
            tail_d  = 2'd0;
            count_d = 2'd0;
        end else begin
            if (wr_en) begin
                mem_d[tail_q] = wr_data;
                tail_d        = ptr_inc(tail_q);
            end
            if (rd_en) begin
                head_d = ptr_inc(head_q);
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= 2'd0;
            tail_q  <= 2'd0;
            count_q <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/async_fifo_rd_stage.sv
// Read-side consumer for async_fifo_top: pops the FIFO on credit, feeds a
// first-word-fall-through stream, and can drain the FIFO on flush.
//
//   state | meaning
//   RUN   | normal streaming; pops limited by buffer credit
//   DRAIN | pop and discard everything until flush drops and FIFO is empty
module async_fifo_rd_stage
    import async_fifo_pkg::*;
#(
    parameter int DWIDTH = FIFO_DWIDTH,
    parameter int CNTW   = 16
) (
    input  logic              rclk,
    input  logic              reset_L,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_rdata,
    output logic              fifo_pop,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic              flush_done,
    output logic [1:0]        buf_count,
    output logic [CNTW-1:0]   deliv_count,
    output logic [CNTW-1:0]   drain_count
);

    localparam logic [2:0] DEPTH3 = 3'(RD_BUF_DEPTH);

    rd_state_t         state_q, state_d;
    logic              inflight_q, inflight_d;
    logic              flush_done_q, flush_done_d;
    logic [CNTW-1:0]   deliv_q, deliv_d;
    logic [CNTW-1:0]   drain_q, drain_d;

    logic [1:0]        count;
    logic [DWIDTH-1:0] head_data;
    logic              in_run;
    logic              credit_ok;
    logic              xfer;
    logic              buf_wr;
    logic              buf_clear;
    logic              discard;

    rd_elastic_buf #(
        .DWIDTH (DWIDTH)
    ) u_buf (
        .clk       (rclk),
        .reset_L   (reset_L),
        .clear     (buf_clear),
        .wr_en     (buf_wr),
        .wr_data   (fifo_rdata),
        .rd_en     (xfer),
        .head_data (head_data),
        .count     (count)
    );

    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        fifo_pop     = 1'b0;

        in_run    = (state_q == RUN);
        // Credit uses registered count/inflight only, so out_ready never reaches fifo_pop.
        credit_ok = (({1'b0, count} + {2'b00, inflight_q}) < DEPTH3);
        out_valid = in_run && (count != 2'd0);
        xfer      = out_valid && out_ready;
        buf_clear = in_run && flush;
        buf_wr    = in_run && !flush && inflight_q;
        // A word returning on the flush edge belongs to the drain, not the buffer.
        discard   = inflight_q && (!in_run || flush);

        case (state_q)
            RUN: begin
                fifo_pop = reset_L && !fifo_empty && !flush && credit_ok;
                if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                fifo_pop = reset_L && !fifo_empty;
                if (!flush && fifo_empty && !inflight_q) begin
                    state_d      = RUN;
                    flush_done_d = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        inflight_d = fifo_pop;
        deliv_d    = deliv_q + CNTW'(xfer);
        drain_d    = drain_q + CNTW'(discard);
    end

    always_ff @(posedge rclk) begin
        if (!reset_L) begin
            state_q      <= RUN;
            inflight_q   <= 1'b0;
            flush_done_q <= 1'b0;
            deliv_q      <= '0;
            drain_q      <= '0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            flush_done_q <= flush_done_d;
            deliv_q      <= deliv_d;
            drain_q      <= drain_d;
        end
    end

    assign out_data    = head_data;
    assign buf_count   = count;
    assign flush_done  = flush_done_q;
    assign deliv_count = deliv_q;
    assign drain_count = drain_q;

endmodule

// File: tb/tb_async_fifo_rd_stage.sv
// Bench for async_fifo_rd_stage: queue-based FIFO model plus an output scoreboard.
module tb_async_fifo_rd_stage;

    localparam int DW   = 8;
    localparam int CW   = 4;
    localparam int CMOD = 1 << CW;

    logic          rclk = 1'b0;
    logic          reset_L = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_pop;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic          flush_done;
    logic [1:0]    buf_count;
    logic [CW-1:0] deliv_count;
    logic [CW-1:0] drain_count;

    int total = 0;
    int bad   = 0;

    always #5 rclk = ~rclk;

    async_fifo_rd_stage #(
        .DWIDTH (DW),
        .CNTW   (CW)
    ) dut (
        .rclk        (rclk),
        .reset_L     (reset_L),
        .fifo_empty  (fifo_empty),
        .fifo_rdata  (fifo_rdata),
        .fifo_pop    (fifo_pop),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .flush       (flush),
        .flush_done  (flush_done),
        .buf_count   (buf_count),
        .deliv_count (deliv_count),
        .drain_count (drain_count)
    );

    // FIFO model: words enter via push_q, pop returns data one cycle later.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] push_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] env_w;
    bit            discard_mode = 1'b0;
    bit            pop_prev = 1'b0;
    int            pops_total = 0;

    always @(posedge rclk) begin
        pop_prev = fifo_pop;
        if (fifo_pop && fq.size() > 0) begin
            env_w = fq.pop_front();
            fifo_rdata <= env_w;
            pops_total++;
            if (!discard_mode) exp_q.push_back(env_w);
        end else begin
            fifo_rdata <= DW'($urandom);
        end
        while (push_q.size() > 0) fq.push_back(push_q.pop_front());
        fifo_empty <= (fq.size() == 0);
    end

    // Output scoreboard and interface rules, sampled mid-cycle.
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] mon_w;
    int            nxfer = 0;
    int            m_deliv = 0;

    always @(negedge rclk) begin
        total++;
        if (fifo_pop && fifo_empty) begin
            bad++;
            $display("FAIL pop_while_empty: fifo_pop=%0b with fifo_empty=%0b, required fifo_pop=0", fifo_pop, fifo_empty);
        end
        total++;
        if (int'(buf_count) + int'(pop_prev) > 3) begin
            bad++;
            $display("FAIL credit: buf_count=%0d inflight=%0b, required sum<=3", buf_count, pop_prev);
        end
        if (!reset_L || flush) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    bad++;
                    $display("FAIL stall_hold: valid=%0b data=%02h, required valid=1 data=%02h", out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL xfer_extra: got data=%02h, required no transfer", out_data);
                end else begin
                    mon_w = exp_q.pop_front();
                    if (out_data !== mon_w) begin
                        bad++;
                        $display("FAIL xfer_data: got %02h, required %02h", out_data, mon_w);
                    end
                end
                nxfer++;
                m_deliv = (m_deliv + 1) % CMOD;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge rclk);
        #2;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        total += 7;
        if (out_valid !== 1'b0)  begin bad++; $display("FAIL rst_valid: got %0b, required 0", out_valid); end
        if (out_data !== '0)     begin bad++; $display("FAIL rst_data: got %02h, required 00", out_data); end
        if (fifo_pop !== 1'b0)   begin bad++; $display("FAIL rst_pop: got %0b, required 0", fifo_pop); end
        if (flush_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0b, required 0", flush_done); end
        if (buf_count !== 2'd0)  begin bad++; $display("FAIL rst_count: got %0d, required 0", buf_count); end
        if (deliv_count !== '0)  begin bad++; $display("FAIL rst_deliv: got %0d, required 0", deliv_count); end
        if (drain_count !== '0)  begin bad++; $display("FAIL rst_drain: got %0d, required 0", drain_count); end
        reset_L = 1'b1;
        m_deliv = 0;
        exp_q.delete();
        repeat (2) tick();
    endtask

    task automatic test_basic();
        int pop_cyc = -1;
        int val_cyc = -1;
        logic [DW-1:0] got[$];
        int gcyc[$];
        for (int i = 1; i <= 5; i++) push_q.push_back(DW'(i));
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge rclk);
            if (fifo_pop && pop_cyc < 0) pop_cyc = c;
            if (out_valid && val_cyc < 0) val_cyc = c;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                gcyc.push_back(c);
            end
            tick();
        end
        total++;
        if (pop_cyc < 0 || val_cyc - pop_cyc != 2) begin
            bad++;
            $display("FAIL basic_latency: pop->valid=%0d cycles, required 2", val_cyc - pop_cyc);
        end
        total++;
        if (got.size() != 5) begin
            bad++;
            $display("FAIL basic_count: got %0d words, required 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (got[i] !== DW'(i + 1) || gcyc[i] != gcyc[0] + i) begin
                    bad++;
                    $display("FAIL basic_word%0d: got %02h at cycle %0d, required %02h at cycle %0d", i, got[i], gcyc[i], i + 1, gcyc[0] + i);
                end
            end
        end
        total++;
        if (deliv_count !== CW'(5)) begin
            bad++;
            $display("FAIL basic_deliv: got %0d, required 5", deliv_count);
        end
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int n0 = nxfer;
        for (int i = 0; i < 16; i++) push_q.push_back(DW'($urandom));
        for (int c = 0; c < 300; c++) begin
            out_ready = pat[c % 4];
            tick();
            if (nxfer - n0 >= 16) break;
        end
        out_ready = 1'b0;
        repeat (3) tick();
        total++;
        if (nxfer - n0 != 16) begin
            bad++;
            $display("FAIL stream_count: got %0d transfers, required 16", nxfer - n0);
        end
        total++;
        if (exp_q.size() != 0 || buf_count !== 2'd0) begin
            bad++;
            $display("FAIL stream_left: %0d words pending, buf_count=%0d, required 0 and 0", exp_q.size(), buf_count);
        end
        total++;
        if (deliv_count !== CW'(m_deliv)) begin
            bad++;
            $display("FAIL stream_deliv: got %0d, required %0d", deliv_count, m_deliv);
        end
    endtask

    task automatic test_backpressure();
        int p0 = pops_total;
        int n0 = nxfer;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_q.push_back(DW'($urandom));
        repeat (12) tick();
        total += 3;
        if (pops_total - p0 != 3) begin bad++; $display("FAIL bp_pops: got %0d pops, required 3", pops_total - p0); end
        if (buf_count !== 2'd3)    begin bad++; $display("FAIL bp_count: got %0d, required 3", buf_count); end
        if (fifo_pop !== 1'b0)     begin bad++; $display("FAIL bp_pop_stalled: got %0b, required 0", fifo_pop); end
        out_ready = 1'b1;
        #1;
        total++;
        if (fifo_pop !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_first_xfer: pop=%0b valid=%0b, required pop=0 valid=1", fifo_pop, out_valid);
        end
        tick();
        total++;
        if (fifo_pop !== 1'b1) begin
            bad++;
            $display("FAIL bp_resume_pop: got %0b, required 1", fifo_pop);
        end
        for (int c = 0; c < 100; c++) begin
            if (nxfer - n0 >= 10) break;
            tick();
        end
        out_ready = 1'b0;
        repeat (3) tick();
        total++;
        if (nxfer - n0 != 10 || pops_total - p0 != 10) begin
            bad++;
            $display("FAIL bp_total: got %0d transfers %0d pops, required 10 and 10", nxfer - n0, pops_total - p0);
        end
    endtask

    task automatic test_flush();
        int  done_cnt = 0;
        bit  empty_at_done = 1'b0;
        int  d0 = m_deliv;
        logic [CW-1:0] dr0 = drain_count;
        out_ready = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 7; i++) push_q.push_back(DW'($urandom));
        repeat (4) tick();
        flush = 1'b1;
        discard_mode = 1'b1;
        #1;
        total += 2;
        if (buf_count !== 2'd2 || pop_prev !== 1'b1) begin
            bad++;
            $display("FAIL flush_setup: buf_count=%0d inflight=%0b, required 2 and 1", buf_count, pop_prev);
        end
        if (fifo_pop !== 1'b0) begin
            bad++;
            $display("FAIL flush_pop: got %0b, required 0", fifo_pop);
        end
        tick();
        flush = 1'b0;
        exp_q.delete();
        total++;
        if (out_valid !== 1'b0 || buf_count !== 2'd0) begin
            bad++;
            $display("FAIL flush_clear: valid=%0b buf_count=%0d, required 0 and 0", out_valid, buf_count);
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            if (flush_done) begin
                done_cnt++;
                empty_at_done = fifo_empty;
            end
        end
        discard_mode = 1'b0;
        total += 3;
        if (done_cnt != 1 || !empty_at_done) begin
            bad++;
            $display("FAIL flush_done: got %0d pulses (fifo_empty=%0b), required 1 with empty", done_cnt, empty_at_done);
        end
        if (drain_count !== CW'(dr0 + CW'(5))) begin
            bad++;
            $display("FAIL flush_drain: got %0d, required %0d", drain_count, CW'(dr0 + CW'(5)));
        end
        if (deliv_count !== CW'(d0)) begin
            bad++;
            $display("FAIL flush_deliv: got %0d, required %0d", deliv_count, d0);
        end
    endtask

    task automatic test_flush_hold();
        int early = 0;
        int late = 0;
        logic [CW-1:0] dr0 = drain_count;
        flush = 1'b1;
        repeat (6) begin
            tick();
            if (flush_done) early++;
        end
        total++;
        if (early != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_drain: %0d pulses valid=%0b while flush high, required 0 and 0", early, out_valid);
        end
        flush = 1'b0;
        repeat (5) begin
            tick();
            if (flush_done) late++;
        end
        total += 2;
        if (late != 1) begin
            bad++;
            $display("FAIL hold_release: got %0d pulses, required 1", late);
        end
        if (drain_count !== dr0) begin
            bad++;
            $display("FAIL hold_drain_count: got %0d, required %0d", drain_count, dr0);
        end
    endtask

    task automatic test_reset_mid();
        int rem;
        int n0;
        bit steady = 1'b0;
        for (int i = 0; i < 12; i++) push_q.push_back(DW'($urandom));
        out_ready = 1'b1;
        repeat ($urandom_range(4, 6)) tick();
        for (int c = 0; c < 20; c++) begin
            if (pop_prev && buf_count == 2'd1) begin
                steady = 1'b1;
                break;
            end
            tick();
        end
        reset_L = 1'b0;
        total++;
        if (!steady || pop_prev !== 1'b1) begin
            bad++;
            $display("FAIL mid_setup: inflight=%0b, required 1", pop_prev);
        end
        tick();
        reset_L = 1'b1;
        exp_q.delete();
        m_deliv = 0;
        rem = fq.size();
        total += 2;
        if (out_valid !== 1'b0 || out_data !== '0 || buf_count !== 2'd0 || flush_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_outputs: valid=%0b data=%02h count=%0d done=%0b, required all 0", out_valid, out_data, buf_count, flush_done);
        end
        if (deliv_count !== '0 || drain_count !== '0 || pop_prev !== 1'b0) begin
            bad++;
            $display("FAIL mid_counters: deliv=%0d drain=%0d pop_in_reset=%0b, required 0", deliv_count, drain_count, pop_prev);
        end
        n0 = nxfer;
        for (int c = 0; c < 100; c++) begin
            if (nxfer - n0 >= rem) break;
            tick();
        end
        repeat (4) tick();
        total += 2;
        if (nxfer - n0 != rem || exp_q.size() != 0) begin
            bad++;
            $display("FAIL mid_resume: got %0d transfers (%0d pending), required %0d", nxfer - n0, exp_q.size(), rem);
        end
        if (deliv_count !== CW'(rem % CMOD)) begin
            bad++;
            $display("FAIL mid_deliv: got %0d, required %0d", deliv_count, rem % CMOD);
        end
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        int n0;
        bit wrapped = 1'b0;
        logic [CW-1:0] prev;
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
        exp_q.delete();
        m_deliv = 0;
        prev = deliv_count;
        for (int i = 0; i < 20; i++) push_q.push_back(DW'($urandom));
        out_ready = 1'b1;
        n0 = nxfer;
        for (int c = 0; c < 150; c++) begin
            tick();
            if (prev == CW'(CMOD - 1) && deliv_count == '0) wrapped = 1'b1;
            prev = deliv_count;
            if (nxfer - n0 >= 20) break;
        end
        tick();
        total += 2;
        if (!wrapped) begin
            bad++;
            $display("FAIL wrap_seen: deliv_count never went %0d->0, required a wrap", CMOD - 1);
        end
        if (deliv_count !== CW'(20 % CMOD)) begin
            bad++;
            $display("FAIL wrap_value: got %0d, required %0d", deliv_count, 20 % CMOD);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_hold();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
